fetch_stage: RTL and testbench

//   Fetch stage and IF/ID pipeline register: the consuming end of the hazard

---
 rtl/fetch_stage_if.sv | 34 +++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard-unit stall/redirect controls, decode targets,
// instruction-memory port and the IF/ID register outputs.
interface fetch_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pc_enable;
  logic             instr_enable;
  logic             pc_src;
  logic             jumpD;
  logic [31:0]      branch_target;
  logic [31:0]      jump_target;
  logic [31:0]      instr_in;
  logic [31:0]      pc;
  logic [31:0]      instrD;
  logic [31:0]      pc_plus4D;
  logic             validD;
  logic [1:0]       fetch_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output pc_enable, instr_enable, pc_src, jumpD,
    output branch_target, jump_target, instr_in,
    input  pc, instrD, pc_plus4D, validD, fetch_state,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  pc_enable, instr_enable, pc_src, jumpD,
    input  branch_target, jump_target, instr_in,
    output pc, instrD, pc_plus4D, validD, fetch_state,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID register: next-PC selection, stall/flush handling
// and saturating stall/redirect counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFC;

  logic [1:0]       state, stateNext;
  logic [31:0]      pcQ, pcNext;
  logic [31:0]      instrQ, instrNext;
  logic [31:0]      pcPlus4Q, pcPlus4Next;
  logic             validQ, validNext;
  logic [CNT_W-1:0] stallQ, stallNext;
  logic [CNT_W-1:0] flushQ, flushNext;

  logic        redirect;
  logic [31:0] pcPlus4;

  assign redirect = bus.pc_src | bus.jumpD;
  assign pcPlus4  = pcQ + 32'd4;

  // Next-state and next-register computation; BOOT ignores all controls.
  always_comb begin
    stateNext   = state;
    pcNext      = pcQ;
    instrNext   = instrQ;
    pcPlus4Next = pcPlus4Q;
    validNext   = validQ;
    stallNext   = stallQ;
    flushNext   = flushQ;

    if (state == BOOT) begin
      pcNext      = pcPlus4;
      instrNext   = bus.instr_in;
      pcPlus4Next = pcPlus4;
      validNext   = 1'b1;
      stateNext   = RUN;
    end else begin
      if (bus.pc_enable) begin
        if (bus.jumpD)       pcNext = bus.jump_target & TGT_MASK;
        else if (bus.pc_src) pcNext = bus.branch_target & TGT_MASK;
        else                 pcNext = pcPlus4;
      end

      if (bus.instr_enable) begin
        if (redirect) begin
          instrNext   = 32'h0;
          pcPlus4Next = 32'h0;
          validNext   = 1'b0;
        end else begin
          instrNext   = bus.instr_in;
          pcPlus4Next = pcPlus4;
          validNext   = 1'b1;
        end
      end

      // Counters saturate at all-ones.
      if (!bus.pc_enable) begin
        if (stallQ != {CNT_W{1'b1}}) stallNext = stallQ + CNT_W'(1);
      end else if (redirect) begin
        if (flushQ != {CNT_W{1'b1}}) flushNext = flushQ + CNT_W'(1);
      end

      if (!bus.pc_enable) stateNext = STALL;
      else if (redirect)  stateNext = FLUSH;
      else                stateNext = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pcQ      <= RESET_PC;
      instrQ   <= 32'h0;
      pcPlus4Q <= 32'h0;
      validQ   <= 1'b0;
      stallQ   <= '0;
      flushQ   <= '0;
    end else begin
      state    <= stateNext;
      pcQ      <= pcNext;
      instrQ   <= instrNext;
      pcPlus4Q <= pcPlus4Next;
      validQ   <= validNext;
      stallQ   <= stallNext;
      flushQ   <= flushNext;
    end
  end

  assign bus.pc           = pcQ;
  assign bus.instrD       = instrQ;
  assign bus.pc_plus4D    = pcPlus4Q;
  assign bus.validD       = validQ;
  assign bus.fetch_state  = state;
  assign bus.stall_cycles = stallQ;
  assign bus.flush_count  = flushQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push hand-computed
// expectations; a monitor pops and compares after each edge or async reset.
module tb_fetch_stage;

  typedef struct {
    bit          sel;
    int          idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        v;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;

  exp_t expQ[$];
  int checks = 0;
  int passes = 0;
  int stepNo = 0;

  fetch_stage_if #(.CNT_W(16)) if1 ();
  fetch_stage_if #(.CNT_W(2))  if2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(if2)
  );

  // Instruction memory stand-in: word at address a is a ^ 32'hA5A5_0000.
  assign if1.instr_in = if1.pc ^ 32'hA5A5_0000;
  assign if2.instr_in = if2.pc ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    else
      passes++;
  endtask

  task automatic step(input bit sel, input logic rst,
                      input logic pe, input logic ie, input logic ps, input logic jd,
                      input logic [31:0] bt, input logic [31:0] jt,
                      input logic [31:0] ePc, input logic [31:0] eIns, input logic [31:0] eP4,
                      input logic eV, input logic [1:0] eSt,
                      input logic [15:0] eSc, input logic [15:0] eFc);
    exp_t e;
    @(negedge clk);
    if (!sel) begin
      if1.pc_enable = pe; if1.instr_enable = ie; if1.pc_src = ps; if1.jumpD = jd;
      if1.branch_target = bt; if1.jump_target = jt; rst_n = rst;
    end else begin
      if2.pc_enable = pe; if2.instr_enable = ie; if2.pc_src = ps; if2.jumpD = jd;
      if2.branch_target = bt; if2.jump_target = jt; rst2_n = rst;
    end
    stepNo++;
    e.sel = sel; e.idx = stepNo; e.pc = ePc; e.instr = eIns; e.p4 = eP4;
    e.v = eV; e.st = eSt; e.sc = eSc; e.fc = eFc;
    expQ.push_back(e);
  endtask

  // Monitor: compares the selected DUT right after each edge / async reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (!e.sel) begin
          chk("pc", e.idx, if1.pc, e.pc);
          chk("instrD", e.idx, if1.instrD, e.instr);
          chk("pc_plus4D", e.idx, if1.pc_plus4D, e.p4);
          chk("validD", e.idx, 32'(if1.validD), 32'(e.v));
          chk("fetch_state", e.idx, 32'(if1.fetch_state), 32'(e.st));
          chk("stall_cycles", e.idx, 32'(if1.stall_cycles), 32'(e.sc));
          chk("flush_count", e.idx, 32'(if1.flush_count), 32'(e.fc));
        end else begin
          chk("pc2", e.idx, if2.pc, e.pc);
          chk("instrD2", e.idx, if2.instrD, e.instr);
          chk("pc_plus4D2", e.idx, if2.pc_plus4D, e.p4);
          chk("validD2", e.idx, 32'(if2.validD), 32'(e.v));
          chk("fetch_state2", e.idx, 32'(if2.fetch_state), 32'(e.st));
          chk("stall_cycles2", e.idx, 32'(if2.stall_cycles), 32'(e.sc));
          chk("flush_count2", e.idx, 32'(if2.flush_count), 32'(e.fc));
        end
      end
    end
  end

  initial begin
    exp_t e;
    int wait_cycles;
    if1.pc_enable = 1; if1.instr_enable = 1; if1.pc_src = 0; if1.jumpD = 0;
    if1.branch_target = 0; if1.jump_target = 0;
    if2.pc_enable = 1; if2.instr_enable = 1; if2.pc_src = 0; if2.jumpD = 0;
    if2.branch_target = 0; if2.jump_target = 0;

    //      sel rst pe ie ps jd  bt        jt          pc            instrD        pc+4D         v  st  stall flush
    step(0, 0, 1, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h0,        32'h0,   0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 32'h40,  32'h80,  32'h4,   32'hA5A5_0000, 32'h4,   1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 32'h0,   32'h0,   32'h8,   32'hA5A5_0004, 32'h8,   1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h8,   32'hA5A5_0004, 32'h8,   1, 2, 1, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h8,   32'hA5A5_0004, 32'h8,   1, 2, 2, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h8,   32'hA5A5_0004, 32'h8,   1, 2, 3, 0);
    step(0, 1, 1, 1, 0, 0, 32'h0,   32'h0,   32'hC,   32'hA5A5_0008, 32'hC,   1, 1, 3, 0);
    step(0, 1, 1, 1, 1, 0, 32'h40,  32'h0,   32'h40,  32'h0,        32'h0,   0, 3, 3, 1);
    step(0, 1, 1, 1, 0, 0, 32'h0,   32'h0,   32'h44,  32'hA5A5_0040, 32'h44,  1, 1, 3, 1);
    step(0, 1, 1, 1, 1, 1, 32'h40,  32'h80,  32'h80,  32'h0,        32'h0,   0, 3, 3, 2);
    step(0, 1, 1, 1, 1, 0, 32'h43,  32'h0,   32'h40,  32'h0,        32'h0,   0, 3, 3, 3);
    step(0, 1, 0, 0, 1, 0, 32'h80,  32'h0,   32'h40,  32'h0,        32'h0,   0, 2, 4, 3);
    step(0, 1, 1, 1, 1, 0, 32'h100, 32'h0,   32'h100, 32'h0,        32'h0,   0, 3, 4, 4);
    step(0, 1, 0, 1, 0, 0, 32'h0,   32'h0,   32'h100, 32'hA5A5_0100, 32'h104, 1, 2, 5, 4);
    step(0, 1, 1, 0, 0, 0, 32'h0,   32'h0,   32'h104, 32'hA5A5_0100, 32'h104, 1, 1, 5, 4);
    step(0, 1, 1, 1, 0, 1, 32'h0,   32'h83,  32'h80,  32'h0,        32'h0,   0, 3, 5, 5);
    step(0, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h80,  32'h0,        32'h0,   0, 2, 6, 5);

    // Asynchronous reset mid-stall, sampled before the next clock edge.
    @(negedge clk);
    if1.pc_enable = 0; if1.instr_enable = 0;
    stepNo++;
    e.sel = 0; e.idx = stepNo; e.pc = 32'h0; e.instr = 32'h0; e.p4 = 32'h0;
    e.v = 0; e.st = 0; e.sc = 16'h0; e.fc = 16'h0;
    expQ.push_back(e);
    #2 rst_n = 0;

    // Wrapping reset PC, target alignment and 2-bit counter saturation.
    step(1, 0, 1, 1, 0, 0, 32'h0,   32'h0,   32'hFFFF_FFFC, 32'h0,  32'h0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 32'h0,   32'h0,   32'h0,   32'h5A5A_FFFC, 32'h0,   1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 1, 32'h0,   32'h83,  32'h80,  32'h0,        32'h0,   0, 3, 0, 1);
    step(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h80,  32'h0,        32'h0,   0, 2, 1, 1);
    step(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h80,  32'h0,        32'h0,   0, 2, 2, 1);
    step(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h80,  32'h0,        32'h0,   0, 2, 3, 1);
    step(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h80,  32'h0,        32'h0,   0, 2, 3, 1);
    step(1, 1, 1, 1, 1, 0, 32'h40,  32'h0,   32'h40,  32'h0,        32'h0,   0, 3, 3, 2);
    step(1, 1, 1, 1, 1, 0, 32'h40,  32'h0,   32'h40,  32'h0,        32'h0,   0, 3, 3, 3);
    step(1, 1, 1, 1, 1, 0, 32'h40,  32'h0,   32'h40,  32'h0,        32'h0,   0, 3, 3, 3);

    wait_cycles = 0;
    while (expQ.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
